// File: rtl/mult_pipe_pkg.sv
// Shared width definitions for the multiplier and its companion divider.
// Both blocks import these so a divider/multiplier pair always agrees on
// quotient, divisor and remainder widths.
package mult_pipe_pkg;

    // Default multiplicand (quotient) width
    localparam int DEF_N = 5;
    // Default multiplier (divisor) and addend (remainder) width
    localparam int DEF_M = 3;

    // Product width wide enough that a*b + c can never overflow
    function automatic int prod_width(input int n, input int m);
        return n + m;
    endfunction

endpackage

// File: rtl/mult_pipe_cell.sv
// One pipeline stage of the shift-add multiplier. Stage K adds the
// multiplicand shifted by K when multiplier bit K is set, then forwards the
// operands and the running sum to the next stage.
// Optional MULT_TAG_EN carries a user tag alongside the operands.
import mult_pipe_pkg::*;

module mult_cell #(
    parameter int N = DEF_N,
    parameter int M = DEF_M,
    parameter int K = 0
`ifdef MULT_TAG_EN
    ,
    parameter int T = 1
`endif
) (
    input  logic                         clk,
    input  logic                         rstn,
    input  logic                         v_in,
    input  logic [prod_width(N,M)-1:0]   acc_in,
    input  logic [N-1:0]                 mcand_in,
    input  logic [M-1:0]                 mplier_in,
`ifdef MULT_TAG_EN
    input  logic [T-1:0]                 tag_in,
    output logic [T-1:0]                 tag_out,
`endif
    output logic                         v_out,
    output logic [prod_width(N,M)-1:0]   acc_out,
    output logic [N-1:0]                 mcand_out,
    output logic [M-1:0]                 mplier_out
);

    localparam int P = prod_width(N, M);

    logic [P-1:0] partial;
    logic [P-1:0] acc_next;

    // Partial product for this bit and the running sum it feeds
    always_comb begin
        partial = '0;
        if (mplier_in[K]) begin
            partial = P'(mcand_in) << K;
        end
        acc_next = acc_in + partial;
    end

    // Valid always advances; data registers only load behind a valid bit so
    // the last result stays visible at the pipe output between operations
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            v_out      <= 1'b0;
            acc_out    <= '0;
            mcand_out  <= '0;
            mplier_out <= '0;
`ifdef MULT_TAG_EN
            tag_out    <= '0;
`endif
        end else begin
            v_out <= v_in;
            if (v_in) begin
                acc_out    <= acc_next;
                mcand_out  <= mcand_in;
                mplier_out <= mplier_in;
`ifdef MULT_TAG_EN
                tag_out    <= tag_in;
`endif
            end
        end
    end

endmodule

// File: rtl/mult_pipe.sv
// Pipelined shift-add multiplier-accumulator: product = multiplicand *
// multiplier + addend. One stage per multiplier bit, one op per cycle,
// latency M cycles, no backpressure. Used to rebuild dividends from the
// restoring divider's quotient/divisor/remainder.
// Optional feature macro: MULT_TAG_EN (adds tag_i/tag_o carried with the op).
import mult_pipe_pkg::*;

module mult_pipe #(
    parameter int N = DEF_N,
    parameter int M = DEF_M
`ifdef MULT_TAG_EN
    ,
    parameter int T = 1
`endif
) (
    input  logic                 clk,
    input  logic                 rstn,
    input  logic                 data_rdy,
    input  logic [N-1:0]         multiplicand,
    input  logic [M-1:0]         multiplier,
    input  logic [M-1:0]         addend,
`ifdef MULT_TAG_EN
    input  logic [T-1:0]         tag_i,
    output logic [T-1:0]         tag_o,
`endif
    output logic                 res_rdy,
    output logic [N+M-1:0]       product
);

    localparam int P = prod_width(N, M);

    // Index 0 is the pipe input; index k+1 is the output of stage k
    logic         v_s      [0:M];
    logic [P-1:0] acc_s    [0:M];
    logic [N-1:0] mcand_s  [0:M];
    logic [M-1:0] mplier_s [0:M];
`ifdef MULT_TAG_EN
    logic [T-1:0] tag_s    [0:M];
`endif

    // Seed stage 0: the addend starts the accumulation, zero-extended
    always_comb begin
        v_s[0]      = data_rdy;
        acc_s[0]    = P'(addend);
        mcand_s[0]  = multiplicand;
        mplier_s[0] = multiplier;
`ifdef MULT_TAG_EN
        tag_s[0]    = tag_i;
`endif
    end

    for (genvar k = 0; k < M; k++) begin : g_stage
        mult_cell #(
            .N (N),
            .M (M),
            .K (k)
`ifdef MULT_TAG_EN
            ,
            .T (T)
`endif
        ) u_cell (
            .clk        (clk),
            .rstn       (rstn),
            .v_in       (v_s[k]),
            .acc_in     (acc_s[k]),
            .mcand_in   (mcand_s[k]),
            .mplier_in  (mplier_s[k]),
`ifdef MULT_TAG_EN
            .tag_in     (tag_s[k]),
            .tag_out    (tag_s[k+1]),
`endif
            .v_out      (v_s[k+1]),
            .acc_out    (acc_s[k+1]),
            .mcand_out  (mcand_s[k+1]),
            .mplier_out (mplier_s[k+1])
        );
    end

    // Last stage drives the outputs directly; its registers provide the hold
    always_comb begin
        res_rdy = v_s[M];
        product = acc_s[M];
`ifdef MULT_TAG_EN
        tag_o   = tag_s[M];
`endif
    end

endmodule

// File: tb/tb_mult_pipe.sv
// Self-checking bench for mult_pipe: directed and random operations checked
// against an arithmetic reference (a*b+c, or the original dividend) with
// expected arrival times derived from the M-cycle latency.
module tb_mult_pipe;

    localparam int N = 5;
    localparam int M = 3;
    localparam int P = N + M;

    logic         clk = 1'b0;
    logic         rstn = 1'b0;
    logic         data_rdy = 1'b0;
    logic [N-1:0] multiplicand = '0;
    logic [M-1:0] multiplier = '0;
    logic [M-1:0] addend = '0;
    logic         res_rdy;
    logic [P-1:0] product;
`ifdef MULT_TAG_EN
    logic [0:0]   tag_i = '0;
    logic [0:0]   tag_o;
`endif

    mult_pipe #(.N(N), .M(M)) dut (
        .clk          (clk),
        .rstn         (rstn),
        .data_rdy     (data_rdy),
        .multiplicand (multiplicand),
        .multiplier   (multiplier),
        .addend       (addend),
`ifdef MULT_TAG_EN
        .tag_i        (tag_i),
        .tag_o        (tag_o),
`endif
        .res_rdy      (res_rdy),
        .product      (product)
    );

    always #5 clk = ~clk;

    typedef struct {
        int unsigned val;
        int          edge_no;
        int unsigned tag;
    } exp_t;

    exp_t        exp_q[$];
    int          edge_cnt = 0;
    int          n_cmp = 0;
    int          n_err = 0;
    int unsigned last_exp = 0;
    int unsigned last_tag = 0;
    bit          due;

    always @(posedge clk) edge_cnt++;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_cmp++;
        assert (obs === expv) else begin
            n_err++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, expv);
        end
    endtask

    // Monitor: result must appear exactly on its due cycle, else output holds
    always @(negedge clk) begin
        if (rstn) begin
            due = (exp_q.size() > 0) && (exp_q[0].edge_no == edge_cnt);
            check("res_rdy_timing", {31'd0, res_rdy}, {31'd0, due});
            if (due) begin
                check("product", {24'd0, product}, exp_q[0].val);
`ifdef MULT_TAG_EN
                check("tag_o", {31'd0, tag_o}, exp_q[0].tag);
`endif
                last_exp = exp_q[0].val;
                last_tag = exp_q[0].tag;
                void'(exp_q.pop_front());
            end else begin
                check("product_hold", {24'd0, product}, last_exp);
`ifdef MULT_TAG_EN
                check("tag_hold", {31'd0, tag_o}, last_tag);
`endif
            end
        end
    end

    // Drive one operation; it is sampled on the next rising edge
    task automatic do_op(input int unsigned a, input int unsigned b, input int unsigned c,
                         input int unsigned t, input int unsigned expv);
        exp_t e;
        @(negedge clk);
        data_rdy     = 1'b1;
        multiplicand = N'(a);
        multiplier   = M'(b);
        addend       = M'(c);
`ifdef MULT_TAG_EN
        tag_i        = 1'(t);
`endif
        e.val     = expv;
        e.edge_no = edge_cnt + M;
        e.tag     = t;
        exp_q.push_back(e);
    endtask

    task automatic op(input int unsigned a, input int unsigned b, input int unsigned c);
        do_op(a, b, c, 0, a * b + c);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            data_rdy     = 1'b0;
            multiplicand = N'($urandom);
            multiplier   = M'($urandom);
            addend       = M'($urandom);
        end
    endtask

    task automatic drain();
        int budget;
        budget = 4 * M + 10;
        while (exp_q.size() > 0 && budget > 0) begin
            @(negedge clk);
            budget--;
        end
        idle(2);
        check("drain_empty", exp_q.size(), 0);
    endtask

    initial begin
        #1;
        check("reset_res_rdy", {31'd0, res_rdy}, 0);
        check("reset_product", {24'd0, product}, 0);
        repeat (2) @(negedge clk);
        rstn = 1'b1;

        // Basic single op
        do_op(6, 3, 1, 0, 19);
        idle(5);

        // Extremes
        do_op(31, 7, 6, 0, 223);
        do_op(31, 7, 7, 0, 224);
        do_op(0, 5, 4, 0, 4);
        do_op(9, 0, 2, 0, 2);
        idle(1);
        drain();

        // Streaming 8 / gap 2 / 3
        for (int i = 0; i < 8; i++) op($urandom_range(31), $urandom_range(7), $urandom_range(7));
        idle(2);
        for (int i = 0; i < 3; i++) op($urandom_range(31), $urandom_range(7), $urandom_range(7));
        idle(1);
        drain();

        // Divider round trip, streamed back-to-back
        do_op(5, 5, 4, 0, 29);
        for (int d = 0; d < 32; d++) begin
            for (int dv = 1; dv < 8; dv++) begin
                do_op(d / dv, dv, d % dv, 0, d);
            end
        end
        idle(1);
        drain();

        // Reset with two operations in flight
        op(17, 6, 3);
        op(22, 5, 1);
        @(posedge clk);
        #2;
        rstn     = 1'b0;
        data_rdy = 1'b0;
        exp_q.delete();
        last_exp = 0;
        last_tag = 0;
        #1;
        check("midrst_res_rdy", {31'd0, res_rdy}, 0);
        check("midrst_product", {24'd0, product}, 0);
        repeat (2) @(negedge clk);
        rstn = 1'b1;
        idle(4);
        do_op(3, 2, 1, 0, 7);
        idle(1);
        drain();

`ifdef MULT_TAG_EN
        do_op(4, 3, 2, 0, 14);
        do_op(5, 2, 0, 1, 10);
        do_op(7, 7, 1, 0, 50);
        do_op(1, 1, 1, 1, 2);
        idle(1);
        drain();
`endif

        // Random mix of ops and gaps
        for (int i = 0; i < 60; i++) begin
            if ($urandom_range(3) == 0) idle(1);
            else op($urandom_range(31), $urandom_range(7), $urandom_range(7));
        end
        idle(1);
        drain();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

endmodule
